// File: rtl/change_pattern_gen.sv
// change_pattern_gen: drives the 'change' line with a configurable pattern.
// A pattern is 'repeat' bursts of change=1, each run_len cycles long and
// separated by gap_len cycles of change=0, followed by a one-cycle done pulse.
// All outputs are registered so the change line cannot glitch.
module change_pattern_gen #(
   parameter int RUN_W = 4,
   parameter int GAP_W = 8,
   parameter int REP_W = 8
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [RUN_W-1:0] i_run_len,
   input  logic [GAP_W-1:0] i_gap_len,
   input  logic [REP_W-1:0] i_repeat,
   output logic             o_change,
   output logic             o_busy,
   output logic             o_done,
   output logic [REP_W-1:0] o_bursts_sent
);

   // One down-counter is shared by RUN and GAP, so it must hold either length.
   localparam int CNT_W = (RUN_W > GAP_W) ? RUN_W : GAP_W;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_GAP  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t             r_state,     w_state_next;
   logic [RUN_W-1:0]   r_run_len,   w_run_len_next;
   logic [GAP_W-1:0]   r_gap_len,   w_gap_len_next;
   logic [REP_W-1:0]   r_rep_left,  w_rep_left_next;
   logic [CNT_W-1:0]   r_cnt,       w_cnt_next;
   logic [REP_W-1:0]   r_bursts,    w_bursts_next;
   logic               r_change;
   logic               r_busy;
   logic               r_done;

   // State, latched parameters, counters and registered Moore outputs.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state    <= S_IDLE;
         r_run_len  <= '0;
         r_gap_len  <= '0;
         r_rep_left <= '0;
         r_cnt      <= '0;
         r_bursts   <= '0;
         r_change   <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_run_len  <= w_run_len_next;
         r_gap_len  <= w_gap_len_next;
         r_rep_left <= w_rep_left_next;
         r_cnt      <= w_cnt_next;
         r_bursts   <= w_bursts_next;
         // Outputs are decoded from the next state so they land in flops
         // aligned with the state they describe.
         r_change   <= (w_state_next == S_RUN);
         r_busy     <= (w_state_next == S_RUN) || (w_state_next == S_GAP);
         r_done     <= (w_state_next == S_DONE);
      end
   end

   // Next-state logic: burst/gap sequencing, abort handling, burst counting.
   always_comb begin
      w_state_next    = r_state;
      w_run_len_next  = r_run_len;
      w_gap_len_next  = r_gap_len;
      w_rep_left_next = r_rep_left;
      w_cnt_next      = r_cnt;
      w_bursts_next   = r_bursts;

      case (r_state)
         S_IDLE: begin
            // abort in IDLE drops a simultaneous start
            if (i_start && !i_abort) begin
               w_run_len_next  = i_run_len;
               w_gap_len_next  = i_gap_len;
               w_rep_left_next = i_repeat;
               w_bursts_next   = '0;
               if ((i_run_len != '0) && (i_repeat != '0)) begin
                  w_state_next = S_RUN;
                  w_cnt_next   = CNT_W'(i_run_len);
               end else begin
                  w_state_next = S_DONE;
               end
            end
         end

         S_RUN: begin
            if (i_abort) begin
               w_state_next = S_IDLE;
            end else if (r_cnt <= CNT_W'(1)) begin
               // last cycle of this burst
               if (r_bursts != '1) begin
                  w_bursts_next = r_bursts + REP_W'(1);
               end
               if (r_rep_left <= REP_W'(1)) begin
                  w_state_next = S_DONE;
               end else begin
                  w_rep_left_next = r_rep_left - REP_W'(1);
                  if (r_gap_len != '0) begin
                     w_state_next = S_GAP;
                     w_cnt_next   = CNT_W'(r_gap_len);
                  end else begin
                     // zero gap: bursts merge into one long high stretch
                     w_state_next = S_RUN;
                     w_cnt_next   = CNT_W'(r_run_len);
                  end
               end
            end else begin
               w_cnt_next = r_cnt - CNT_W'(1);
            end
         end

         S_GAP: begin
            if (i_abort) begin
               w_state_next = S_IDLE;
            end else if (r_cnt <= CNT_W'(1)) begin
               w_state_next = S_RUN;
               w_cnt_next   = CNT_W'(r_run_len);
            end else begin
               w_cnt_next = r_cnt - CNT_W'(1);
            end
         end

         S_DONE: begin
            w_state_next = S_IDLE;
         end

         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   assign o_change      = r_change;
   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_bursts_sent = r_bursts;

endmodule

// File: tb/tb_change_pattern_gen.sv
// Bench for change_pattern_gen: directed scenarios then random patterns,
// every cycle compared against a waveform model built from the pattern rules.
module tb_change_pattern_gen;

   logic       i_clock = 1'b0;
   logic       i_reset = 1'b1;
   logic       i_start = 1'b0;
   logic       i_abort = 1'b0;
   logic [3:0] i_run_len = '0;
   logic [7:0] i_gap_len = '0;
   logic [7:0] i_repeat = '0;
   logic       o_change;
   logic       o_busy;
   logic       o_done;
   logic [7:0] o_bursts_sent;

   int errors = 0;
   int checks = 0;

   change_pattern_gen #(.RUN_W(4), .GAP_W(8), .REP_W(8)) dut (
      .i_clock       (i_clock),
      .i_reset       (i_reset),
      .i_start       (i_start),
      .i_abort       (i_abort),
      .i_run_len     (i_run_len),
      .i_gap_len     (i_gap_len),
      .i_repeat      (i_repeat),
      .o_change      (o_change),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_bursts_sent (o_bursts_sent)
   );

   always #5 i_clock = ~i_clock;

   // Expected outputs for one cycle.
   typedef struct packed {
      logic       ch;
      logic       bz;
      logic       dn;
      logic [7:0] bs;
   } exp_t;

   exp_t cur;       // expected outputs in the current cycle
   exp_t q[$];      // expected outputs for the following cycles of a pattern

   function automatic exp_t mk(input logic ch, input logic bz, input logic dn, input int bs);
      exp_t e;
      e.ch = ch; e.bz = bz; e.dn = dn; e.bs = 8'(bs);
      return e;
   endfunction

   // Whole pattern written out cycle by cycle from the pattern rules.
   task automatic build(input int run, input int gap, input int rep);
      q.delete();
      if (run == 0 || rep == 0) begin
         q.push_back(mk(0, 0, 1, 0));
      end else begin
         for (int b = 0; b < rep; b++) begin
            for (int c = 0; c < run; c++) q.push_back(mk(1, 1, 0, b));
            if (b < rep - 1)
               for (int c = 0; c < gap; c++) q.push_back(mk(0, 1, 0, b + 1));
         end
         q.push_back(mk(0, 0, 1, rep));
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit model_active();
      return cur.bz || cur.dn;
   endfunction

   // One clock: drive inputs, advance the model across the edge, then compare.
   task automatic step(input bit s, input bit a, input bit r,
                       input int run, input int gap, input int rep);
      bit was_active;
      i_start = s; i_abort = a; i_reset = r;
      i_run_len = 4'(run); i_gap_len = 8'(gap); i_repeat = 8'(rep);
      was_active = model_active();
      @(posedge i_clock);
      if (r) begin
         q.delete();
         cur = mk(0, 0, 0, 0);
      end else if (was_active) begin
         if (a) begin
            q.delete();
            cur = mk(0, 0, 0, cur.bs);
         end else if (q.size() > 0) begin
            cur = q.pop_front();
         end else begin
            cur = mk(0, 0, 0, cur.bs);
         end
      end else if (s && !a) begin
         $display("start run=%0d gap=%0d repeat=%0d at %0t", run, gap, rep, $time);
         build(run, gap, rep);
         cur = q.pop_front();
      end
      #1;
      chk("change", 32'(o_change), 32'(cur.ch));
      chk("busy", 32'(o_busy), 32'(cur.bz));
      chk("done", 32'(o_done), 32'(cur.dn));
      chk("bursts_sent", 32'(o_bursts_sent), 32'(cur.bs));
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      cur = mk(0, 0, 0, 0);
      // reset state
      step(0, 0, 1, 0, 0, 0);
      step(1, 0, 1, 3, 2, 2);
      idle(1);

      // 1: single burst of 3, done after, bursts_sent=1
      step(1, 0, 0, 3, 5, 1);
      idle(5);
      // 2: three bursts of 2 with gaps of 4
      step(1, 0, 0, 2, 4, 3);
      idle(17);
      // 3: zero gap merges bursts into one 4-cycle high stretch
      step(1, 0, 0, 2, 0, 2);
      idle(6);
      // 4: degenerate patterns only pulse done
      step(1, 0, 0, 0, 3, 4);
      idle(2);
      step(1, 0, 0, 3, 3, 0);
      idle(2);
      // 5: abort in 2nd RUN cycle, then a normal start 2 cycles later
      step(1, 0, 0, 5, 2, 1);
      idle(1);
      step(0, 1, 0, 0, 0, 0);
      idle(2);
      step(1, 0, 0, 2, 1, 1);
      idle(4);
      // abort together with start in IDLE: start dropped
      step(1, 1, 0, 3, 1, 1);
      idle(2);
      // 6: start during GAP ignored (with new input values), reset in RUN
      step(1, 0, 0, 2, 5, 2);
      idle(3);
      step(1, 0, 0, 7, 1, 9);
      idle(4);
      step(0, 0, 1, 0, 0, 0);
      idle(2);
      // max run length boundary
      step(1, 0, 0, 15, 1, 2);
      idle(34);

      // random patterns with random interference while active
      for (int n = 0; n < 60; n++) begin
         int run, gap, rep, budget;
         run = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 6));
         gap = int'($urandom_range(0, 5));
         rep = int'($urandom_range(0, 4));
         step(1, 0, 0, run, gap, rep);
         budget = 0;
         while (model_active() && budget < 300) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 199) == 0,
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)));
            budget++;
         end
         idle(int'($urandom_range(0, 2)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
